fft_bfly_sched: RTL and testbench
=================================

# fft_bfly_sched

Sequencer for the in-place radix-2 DIT FFT built around the single `butterfly` datapath. It walks all LOG2N stages × N/2 butterflies, generates the A/B data-RAM read addresses and twiddle-ROM address per butterfly, and produces delayed write-back strobes and addresses that are aligned with the butterfly pipeline output. It sits between the top-level FFT control and the data RAM / twiddle ROM / butterfly.

## Interface
- `LOG2N`, 6: log2 of FFT length N (N = 2^LOG2N, minimum 2).
- `LAT`, 4: read-to-writeback latency in cycles: 1 for the synchronous RAM read plus 3 for the butterfly. Minimum 1.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a transform. Sampled only in IDLE.
- `busy` out 1: transform in progress.
- `done` out 1: one-cycle pulse when the final write-back completes.
- `stage` out LOG2N: current stage index, used for the scaling and format select.
- `rd_en` out 1: read strobe to the data RAM.
- `rd_addr_a` out LOG2N: A operand address.
- `rd_addr_b` out LOG2N: B operand address.
- `tw_addr` out LOG2N-1: twiddle ROM index, ROM depth N/2.
- `wr_en` out 1: write strobe for the butterfly X/Y results.
- `wr_addr_a` out LOG2N: X result address.
- `wr_addr_b` out LOG2N: Y result address.

## Operation
- **States:** IDLE, RUN, DRAIN, DONE.
- **Counters:** stage counter `s` (0..LOG2N-1), butterfly counter `k` (0..N/2-1), drain counter `d` (0..LAT-1).
- **IDLE:**
  - `start`=1 → RUN, with `s`=0 and `k`=0.
  - Otherwise stay in IDLE.
- **RUN:** one butterfly is issued per cycle with `rd_en`=1.
  - span = 1<<s.
  - rd_addr_a = ((k>>s)<<(s+1)) | (k & (span-1)).
  - rd_addr_b = rd_addr_a + span.
  - tw_addr = (k & (span-1)) << (LOG2N-1-s).
  - When k = N/2-1: go to DRAIN, set `k`=0 and `d`=0.
- **DRAIN:** `rd_en`=0 for exactly LAT cycles.
  - This prevents a read-after-write hazard across stage boundaries.
  - At d = LAT-1: if s = LOG2N-1 → DONE; otherwise increment `s` and go to RUN.
- **DONE:** `done`=1 and `busy`=0 for one cycle, then IDLE.
- **Write-back path:**
  - `wr_en`, `wr_addr_a` and `wr_addr_b` are `rd_en`, `rd_addr_a` and `rd_addr_b` delayed by exactly LAT cycles through a LAT-deep shift register.
  - This register runs independently of the state machine.
- `start` is ignored in RUN, DRAIN and DONE.
- `busy`=1 in RUN and DRAIN only.
- **Reset mid-transform:** all state, counters, the shift register and all outputs clear immediately. No partial write-back is issued after reset is released.

## Timing
- **Reset values:** `busy`, `done`, `rd_en`, `wr_en` = 0. `stage`, all addresses and `tw_addr` = 0.
- All outputs are registered.
- **Start:** `start` is sampled high at edge E0. Cycle 1 (after E0) carries `busy`=1, `rd_en`=1, k=0, s=0.
- **Stage period:** N/2 + LAT cycles. Stage s issues in cycles 1+s·(N/2+LAT) through s·(N/2+LAT)+N/2.
- **Write-back:** a read issued in cycle c is written back in cycle c+LAT. The last write of stage s lands in the last DRAIN cycle of that stage. The first read of stage s+1 follows in the next cycle.
- **Done:** `done` is asserted in cycle LOG2N·(N/2+LAT)+1.
- **Next start:** the earliest cycle a new `start` is accepted is the cycle after `done`.
- `stage` updates in the same cycle as the first read of the new stage.

## Configuration
- **`FFT_SCHED_STALL_EN` defined:**
  - Adds input port `stall` (1 bit).
  - `stall`=1 in RUN forces `rd_en`=0 and holds `k`, `s` and the addresses. The write-back shift register keeps shifting.
  - `stall` is ignored in IDLE, DRAIN and DONE.
  - Each stalled cycle adds one cycle to the total transform length.
- **Not defined:** no `stall` port; RUN issues every cycle unconditionally.

## Test plan
- **Reset:** hold `rst_n`=0 → all outputs 0. Release, leave `start`=0 for 10 cycles → outputs stay 0 and `busy`=0.
- **Address sequence, LOG2N=3, LAT=4:** pulse `start`. Expect (a,b,tw) per stage:
  - Stage 0: (0,1,0) (2,3,0) (4,5,0) (6,7,0).
  - Stage 1: (0,2,0) (1,3,2) (4,6,0) (5,7,2).
  - Stage 2: (0,4,0) (1,5,1) (2,6,2) (3,7,3).
  - `done` in cycle 25, `busy` low from cycle 25.
- **Write-back alignment:** for every `rd_en` in cycle c, expect `wr_en` with the same addresses in cycle c+4. No `rd_en` and `wr_en` to the same address within a stage boundary window.
- **Start while busy:** pulse `start` in cycle 10 of a transform → no restart, `done` still in cycle 25.
- **Reset mid-transform:** drive `rst_n`=0 in cycle 12 → all outputs 0 asynchronously. After release with no `start`, `wr_en` never asserts.
- **Stall (`FFT_SCHED_STALL_EN` defined):** `stall`=1 for 3 cycles during stage 1 → the address sequence is unchanged and `done` arrives in cycle 28.

Source files
------------

// File: rtl/fft_bfly_sched_if.sv
// Bus between the FFT control / data RAM / twiddle ROM side and fft_bfly_sched.
// Defining FFT_SCHED_STALL_EN adds the stall input.
interface fft_bfly_sched_if #(
    parameter int LOG2N = 6
) ();
    logic             start;
`ifdef FFT_SCHED_STALL_EN
    logic             stall;
`endif
    logic             busy;
    logic             done;
    logic [LOG2N-1:0] stage;
    logic             rd_en;
    logic [LOG2N-1:0] rd_addr_a;
    logic [LOG2N-1:0] rd_addr_b;
    logic [LOG2N-2:0] tw_addr;
    logic             wr_en;
    logic [LOG2N-1:0] wr_addr_a;
    logic [LOG2N-1:0] wr_addr_b;

`ifdef FFT_SCHED_STALL_EN
    modport master (
        output start, stall,
        input  busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               wr_en, wr_addr_a, wr_addr_b
    );
    modport slave (
        input  start, stall,
        output busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               wr_en, wr_addr_a, wr_addr_b
    );
`else
    modport master (
        output start,
        input  busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               wr_en, wr_addr_a, wr_addr_b
    );
    modport slave (
        input  start,
        output busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               wr_en, wr_addr_a, wr_addr_b
    );
`endif
endinterface

// File: rtl/fft_bfly_sched.sv
// In-place radix-2 DIT FFT butterfly sequencer: read/twiddle addresses plus LAT-delayed write-back.
// Optional feature macro: FFT_SCHED_STALL_EN (adds bus.stall to hold issue in RUN).
module fft_bfly_sched #(
    parameter int LOG2N = 6,
    parameter int LAT   = 4
) (
    input logic              clk,
    input logic              rst_n,
    fft_bfly_sched_if.slave  bus
);
    localparam int HW = LOG2N - 1;
    localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state_q, state_n;
    logic [LOG2N-1:0] s_q, s_n;
    logic [HW-1:0]    k_q, k_n;
    logic [DW-1:0]    d_q, d_n;
    logic             issue;
    logic             stall_w;

    logic             busy_q, done_q, rd_en_q;
    logic [LOG2N-1:0] ra_q, rb_q;
    logic [HW-1:0]    tw_q;

    logic [LOG2N-1:0] kx, span, mask, lo, a_n, b_n;
    logic [HW-1:0]    tw_n;

    logic [LAT-1:0]   sr_en;
    logic [LOG2N-1:0] sr_a [LAT];
    logic [LOG2N-1:0] sr_b [LAT];

`ifdef FFT_SCHED_STALL_EN
    assign stall_w = bus.stall;
`else
    assign stall_w = 1'b0;
`endif

    // Outputs are registered from next-state values, so k_q is the butterfly
    // shown this cycle; it only advances once rd_en_q confirms it was issued.
    always_comb begin
        state_n = state_q;
        s_n     = s_q;
        k_n     = k_q;
        d_n     = d_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_n = RUN;
                    s_n     = '0;
                    k_n     = '0;
                    issue   = 1'b1;
                end
            end
            RUN: begin
                if (rd_en_q) begin
                    if (k_q == '1) begin
                        state_n = DRAIN;
                        k_n     = '0;
                        d_n     = '0;
                    end else begin
                        k_n = k_q + HW'(1);
                    end
                end
                issue = (state_n == RUN) && !stall_w;
            end
            DRAIN: begin
                if (d_q == DW'(LAT - 1)) begin
                    if (s_q == LOG2N'(LOG2N - 1)) begin
                        state_n = DONE;
                    end else begin
                        s_n     = s_q + LOG2N'(1);
                        state_n = RUN;
                        issue   = 1'b1;
                    end
                end else begin
                    d_n = d_q + DW'(1);
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // A address inserts a zero at bit s of k; B sets that bit.
    always_comb begin
        kx   = {1'b0, k_n};
        span = LOG2N'(1) << s_n;
        mask = span - LOG2N'(1);
        lo   = kx & mask;
        a_n  = ((kx >> s_n) << (s_n + LOG2N'(1))) | lo;
        b_n  = a_n | span;
        tw_n = HW'(lo << (LOG2N'(HW) - s_n));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            k_q     <= '0;
            d_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            ra_q    <= '0;
            rb_q    <= '0;
            tw_q    <= '0;
        end else begin
            state_q <= state_n;
            s_q     <= s_n;
            k_q     <= k_n;
            d_q     <= d_n;
            busy_q  <= (state_n == RUN) || (state_n == DRAIN);
            done_q  <= (state_n == DONE);
            rd_en_q <= issue;
            if (issue) begin
                ra_q <= a_n;
                rb_q <= b_n;
                tw_q <= tw_n;
            end
        end
    end

    // Write-back delay line, free-running and independent of the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_en <= '0;
            for (int unsigned i = 0; i < LAT; i++) begin
                sr_a[i] <= '0;
                sr_b[i] <= '0;
            end
        end else begin
            sr_en[0] <= rd_en_q;
            sr_a[0]  <= ra_q;
            sr_b[0]  <= rb_q;
            for (int unsigned i = 1; i < LAT; i++) begin
                sr_en[i] <= sr_en[i-1];
                sr_a[i]  <= sr_a[i-1];
                sr_b[i]  <= sr_b[i-1];
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.stage     = s_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr_a = ra_q;
    assign bus.rd_addr_b = rb_q;
    assign bus.tw_addr   = tw_q;
    assign bus.wr_en     = sr_en[LAT-1];
    assign bus.wr_addr_a = sr_a[LAT-1];
    assign bus.wr_addr_b = sr_b[LAT-1];
endmodule

// File: tb/tb_fft_bfly_sched.sv
// Bench for fft_bfly_sched (LOG2N=3, LAT=4): address table, schedule model, reset and stall cases.
module tb_fft_bfly_sched;
    localparam int LOG2N = 3;
    localparam int LAT   = 4;
    localparam int N     = 1 << LOG2N;
    localparam int H     = N / 2;
    localparam int MAXC  = 160;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft_bfly_sched_if #(.LOG2N(LOG2N)) bus ();
    fft_bfly_sched #(.LOG2N(LOG2N), .LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int s;
        int k;
        int a;
        int b;
        int tw;
    } vec_t;
    vec_t tbl[12];

    int n_vec = 0;
    int n_bad = 0;

    int e_busy [MAXC];
    int e_done [MAXC];
    int e_stage[MAXC];
    int e_rd   [MAXC];
    int e_a    [MAXC];
    int e_b    [MAXC];
    int e_tw   [MAXC];
    int e_wr   [MAXC];
    int e_wa   [MAXC];
    int e_wb   [MAXC];
    bit st     [MAXC];
    int dcyc;
    int iss_a[$];
    int iss_b[$];
    int iss_tw[$];

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", nm, c, act, exp);
        end
    endtask

    task automatic chk_zero(input string nm, input int c);
        chk({nm, " busy"},  c, 32'(bus.busy), 0);
        chk({nm, " done"},  c, 32'(bus.done), 0);
        chk({nm, " stage"}, c, 32'(bus.stage), 0);
        chk({nm, " rd_en"}, c, 32'(bus.rd_en), 0);
        chk({nm, " rd_a"},  c, 32'(bus.rd_addr_a), 0);
        chk({nm, " rd_b"},  c, 32'(bus.rd_addr_b), 0);
        chk({nm, " tw"},    c, 32'(bus.tw_addr), 0);
        chk({nm, " wr_en"}, c, 32'(bus.wr_en), 0);
        chk({nm, " wr_a"},  c, 32'(bus.wr_addr_a), 0);
        chk({nm, " wr_b"},  c, 32'(bus.wr_addr_b), 0);
    endtask

    // Schedule model: stages of N/2 issues (plus stall bubbles) then LAT drain cycles.
    task automatic build_model();
        int t, first, span, a;
        for (int i = 0; i < MAXC; i++) begin
            e_busy[i] = 0; e_done[i] = 0; e_stage[i] = 0; e_rd[i] = 0;
            e_a[i] = 0; e_b[i] = 0; e_tw[i] = 0; e_wr[i] = 0; e_wa[i] = 0; e_wb[i] = 0;
        end
        t = 1;
        for (int s = 0; s < LOG2N; s++) begin
            first = t;
            span  = 1 << s;
            for (int k = 0; k < H; k++) begin
                while (t - 1 >= first && st[t-1]) begin
                    e_busy[t] = 1; e_stage[t] = s; t++;
                end
                a = (k / span) * 2 * span + k % span;
                e_busy[t] = 1; e_stage[t] = s; e_rd[t] = 1;
                e_a[t] = a; e_b[t] = a + span; e_tw[t] = (k % span) * (H / span);
                e_wr[t+LAT] = 1; e_wa[t+LAT] = a; e_wb[t+LAT] = a + span;
                t++;
            end
            repeat (LAT) begin
                e_busy[t] = 1; e_stage[t] = s; t++;
            end
        end
        e_done[t] = 1;
        dcyc = t;
    endtask

    // Runs one transform, checking every cycle 1..done+1. start is also driven
    // high in the DONE cycle (must be ignored) and optionally in one busy cycle.
    task automatic run_tr(input string nm, input bit started, input int busy_start_cyc,
                          input bit chain_out, output int dut_done);
        int ov;
        if (!started) begin
            bus.start = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        build_model();
        dut_done = -1;
        iss_a.delete(); iss_b.delete(); iss_tw.delete();
        for (int c = 1; c <= dcyc + 1; c++) begin
            bus.start = (c == busy_start_cyc) || (c == dcyc) || (chain_out && c == dcyc + 1);
`ifdef FFT_SCHED_STALL_EN
            bus.stall = st[c];
`endif
            @(negedge clk);
            chk({nm, " busy"},  c, 32'(bus.busy),  e_busy[c]);
            chk({nm, " done"},  c, 32'(bus.done),  e_done[c]);
            chk({nm, " rd_en"}, c, 32'(bus.rd_en), e_rd[c]);
            chk({nm, " wr_en"}, c, 32'(bus.wr_en), e_wr[c]);
            if (bus.done && dut_done < 0) dut_done = c;
            if (e_busy[c] != 0) chk({nm, " stage"}, c, 32'(bus.stage), e_stage[c]);
            if (e_rd[c] != 0) begin
                chk({nm, " rd_a"}, c, 32'(bus.rd_addr_a), e_a[c]);
                chk({nm, " rd_b"}, c, 32'(bus.rd_addr_b), e_b[c]);
                chk({nm, " tw"},   c, 32'(bus.tw_addr),   e_tw[c]);
            end
            if (bus.rd_en) begin
                iss_a.push_back(int'(bus.rd_addr_a));
                iss_b.push_back(int'(bus.rd_addr_b));
                iss_tw.push_back(int'(bus.tw_addr));
            end
            if (e_wr[c] != 0) begin
                chk({nm, " wr_a"}, c, 32'(bus.wr_addr_a), e_wa[c]);
                chk({nm, " wr_b"}, c, 32'(bus.wr_addr_b), e_wb[c]);
            end
            if (bus.rd_en && bus.wr_en) begin
                ov = (bus.rd_addr_a == bus.wr_addr_a || bus.rd_addr_a == bus.wr_addr_b ||
                      bus.rd_addr_b == bus.wr_addr_a || bus.rd_addr_b == bus.wr_addr_b) ? 1 : 0;
                chk({nm, " rw_overlap"}, c, 32'(ov), 0);
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
`ifdef FFT_SCHED_STALL_EN
        bus.stall = 1'b0;
`endif
    endtask

    task automatic check_table(input string nm);
        chk({nm, " issue_count"}, 0, 32'(iss_a.size()), 12);
        for (int i = 0; i < 12; i++) begin
            if (i < iss_a.size()) begin
                chk($sformatf("%s tbl_a s%0d k%0d", nm, tbl[i].s, tbl[i].k),  i, 32'(iss_a[i]),  tbl[i].a);
                chk($sformatf("%s tbl_b s%0d k%0d", nm, tbl[i].s, tbl[i].k),  i, 32'(iss_b[i]),  tbl[i].b);
                chk($sformatf("%s tbl_tw s%0d k%0d", nm, tbl[i].s, tbl[i].k), i, 32'(iss_tw[i]), tbl[i].tw);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int av[12]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
        int bv[12]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
        int twv[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
        int dd;
        for (int i = 0; i < 12; i++) begin
            tbl[i].s = i / 4; tbl[i].k = i % 4;
            tbl[i].a = av[i]; tbl[i].b = bv[i]; tbl[i].tw = twv[i];
        end
        for (int i = 0; i < MAXC; i++) st[i] = 1'b0;
        bus.start = 1'b0;
`ifdef FFT_SCHED_STALL_EN
        bus.stall = 1'b0;
`endif

        // Reset held, then 10 idle cycles without start.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset", 0);
        rst_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            chk_zero("idle", i);
        end
        @(posedge clk); #1;

        // Nominal transform, start pulsed again in cycle 10.
        run_tr("plan", 1'b0, 10, 1'b0, dd);
        chk("plan done_cycle", 0, 32'(dd), 25);
        check_table("plan");

`ifdef FFT_SCHED_STALL_EN
        for (int c = 10; c < 13; c++) st[c] = 1'b1;
        run_tr("stall", 1'b0, 0, 1'b0, dd);
        chk("stall done_cycle", 0, 32'(dd), 28);
        check_table("stall");
        for (int i = 0; i < MAXC; i++) st[i] = 1'b0;
`endif

        // Reset asserted in cycle 12 mid-transform.
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (11) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1 chk_zero("midrst", 12);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("post_rst wr_en", i, 32'(bus.wr_en), 0);
            chk("post_rst busy",  i, 32'(bus.busy),  0);
        end
        @(posedge clk); #1;

        // Random back-to-back transforms: start accepted the cycle after done.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < MAXC; i++) st[i] = 1'b0;
`ifdef FFT_SCHED_STALL_EN
            for (int c = 1; c < 40; c++) st[c] = ($urandom_range(99) < 25);
`endif
            run_tr($sformatf("rand%0d", r), r > 0, int'($urandom_range(24, 2)), r < 5, dd);
            check_table($sformatf("rand%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
